// File: rtl/dca_lsu_outstanding_tracker_pkg.sv
// Shared definitions for the DCA LSU outstanding-request tracker:
// the clog2 helper used to derive counter and pointer widths, plus bus defaults.
package dca_lsu_outstanding_tracker_pkg;

    localparam int DCA_DEPTH_DEFAULT     = 4;
    localparam int DCA_BW_TAG_DEFAULT    = 1;
    localparam int DCA_BW_RDATA_DEFAULT  = 32;
    localparam int DCA_BW_BURDEN_DEFAULT = 1;

    // Elaboration-time ceil(log2(value)); 0 and 1 both need 0 bits.
    function automatic int dcaClog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dca_tag_fifo.sv
// DEPTH x BW_TAG register FIFO holding the tag of every outstanding request.
// Callers never push when full or pop when empty; clear empties it in one cycle.
module dca_tag_fifo
    import dca_lsu_outstanding_tracker_pkg::*;
#(
    parameter int  DEPTH    = DCA_DEPTH_DEFAULT,
    parameter int  BW_TAG   = DCA_BW_TAG_DEFAULT,
    localparam int BW_COUNT = dcaClog2(DEPTH + 1),
    localparam int BW_PTR   = dcaClog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [BW_TAG-1:0]   push_data_i,
    output logic [BW_TAG-1:0]   head_o,
    output logic [BW_COUNT-1:0] count_o
);

    logic [BW_TAG-1:0]   mem_q [DEPTH];
    logic [BW_PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BW_PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BW_COUNT-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + BW_PTR'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + BW_PTR'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + BW_COUNT'(1);
                2'b01:   count_d = count_q - BW_COUNT'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dca_lsu_outstanding_tracker.sv
// Outstanding-request tracker between the LSU and the LPI response channel.
// Define DCA_OUTSTANDING_CHECK_EN to add the sticky err_o response checker.
module dca_lsu_outstanding_tracker
    import dca_lsu_outstanding_tracker_pkg::*;
#(
    parameter int  DEPTH     = DCA_DEPTH_DEFAULT,
    parameter int  BW_TAG    = DCA_BW_TAG_DEFAULT,
    parameter int  BW_RDATA  = DCA_BW_RDATA_DEFAULT,
    parameter int  BW_BURDEN = DCA_BW_BURDEN_DEFAULT,
    localparam int BW_COUNT  = dcaClog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 stall_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [BW_TAG-1:0]    issue_tag_i,
    input  logic                 resp_valid_i,
    output logic                 resp_ready_o,
    input  logic [BW_RDATA-1:0]  resp_data_i,
    output logic                 resp_fire_o,
    output logic [BW_BURDEN-1:0] resp_fire_burden_o,
    output logic [BW_TAG-1:0]    resp_tag_o,
    output logic                 pending_o,
    output logic                 full_o,
    output logic [BW_COUNT-1:0]  count_o
`ifdef DCA_OUTSTANDING_CHECK_EN
    ,
    output logic                 err_o
`endif
);

    logic                 issue_fire;
    logic                 resp_fire;
    logic [BW_BURDEN-1:0] burden;
    logic [BW_TAG-1:0]    head_tag;
    logic [BW_COUNT-1:0]  count;
    logic                 pending;
    logic                 full;
    logic                 unused_resp_data;

    // Ready gating keeps the FIFO from overflowing or underflowing, so it needs no guards.
    dca_tag_fifo #(
        .DEPTH  (DEPTH),
        .BW_TAG (BW_TAG)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_i),
        .push_i      (issue_fire),
        .pop_i       (resp_fire),
        .push_data_i (issue_tag_i),
        .head_o      (head_tag),
        .count_o     (count)
    );

    assign pending = (count != '0);
    assign full    = (count == BW_COUNT'(DEPTH));

    assign issue_ready_o = enable_i & ~clear_i & ~full;
    assign resp_ready_o  = enable_i & ~clear_i & ~stall_i & pending;
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign resp_fire     = resp_valid_i & resp_ready_o;

    assign burden             = resp_data_i[BW_RDATA-1 -: BW_BURDEN];
    assign resp_fire_o        = resp_fire;
    assign resp_fire_burden_o = resp_fire ? burden : '0;
    assign resp_tag_o         = head_tag;
    assign pending_o          = pending;
    assign full_o             = full;
    assign count_o            = count;

    // Only the burden MSBs of the response payload matter to the tracker.
    assign unused_resp_data = ^resp_data_i;

`ifdef DCA_OUTSTANDING_CHECK_EN
    logic err_q, err_d;
    logic unexpected_resp;
    logic tag_mismatch;

    assign unexpected_resp = resp_valid_i & enable_i & ~stall_i & ~pending;
    assign tag_mismatch    = resp_fire & (burden != head_tag[BW_BURDEN-1:0]);

    always_comb begin
        err_d = err_q;
        if (clear_i) begin
            err_d = 1'b0;
        end else if (unexpected_resp || tag_mismatch) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule
